// File: rtl/qracc_pkg.sv
// qracc_pkg: sequencer state type and accumulator-width helper shared by the MAC sequencer files
package qracc_pkg;

    typedef enum logic [2:0] {IDLE, LOAD_W, SETTLE, LOAD_X, MAC, WAIT_RES, DONE} qracc_seq_state_t;

    function automatic int accBits(input int adc_bits, input int x_bits);
        return adc_bits + x_bits;
    endfunction

endpackage

// File: rtl/qracc_bs_accum.sv
// qracc_bs_accum: per-lane ADC sign extension and bit-serial shift-add accumulation
module qracc_bs_accum
    import qracc_pkg::*;
#(
    parameter int numCols    = 32,
    parameter int numAdcBits = 4,
    parameter int accW       = 6
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         clr_i,
    input  logic                         en_i,
    input  logic [numCols*numAdcBits-1:0] adc_i,
    output logic [numCols*accW-1:0]       acc_o
);

    for (genvar i = 0; i < numCols; i++) begin : g_lane
        logic [accW-1:0] w_ext, r_acc;
        assign w_ext = {{(accW-numAdcBits){adc_i[i*numAdcBits+numAdcBits-1]}}, adc_i[i*numAdcBits +: numAdcBits]};
        always_ff @(posedge clk)
            if (nrst || clr_i) r_acc <= '0;
            else if (en_i) r_acc <= {r_acc[accW-2:0], 1'b0} + w_ext;
        assign acc_o[i*accW +: accW] = r_acc;
    end

endmodule

// File: rtl/qracc_mac_sequencer.sv
// qracc_mac_sequencer: weight-load and bit-serial MAC job sequencer; QRACC_BITSERIAL_ACC_EN enables per-vector shift-add accumulation
module qracc_mac_sequencer
    import qracc_pkg::*;
#(
    parameter int numRows      = 128,
    parameter int numCols      = 32,
    parameter int numAdcBits   = 4,
    parameter int xBits        = 2,
    parameter int settleCycles = 5
) (
    input  logic                                          clk,
    input  logic                                          nrst,
    input  logic                                          start_i,
    input  logic                                          cfg_skip_w_i,
    input  logic [15:0]                                   n_vectors_i,
    input  logic [7:0]                                    n_input_bits_i,
    input  logic                                          w_valid_i,
    output logic                                          w_ready_o,
    input  logic [numCols-1:0]                            w_data_i,
    input  logic                                          x_valid_i,
    output logic                                          x_ready_o,
    input  logic [numRows*xBits-1:0]                      x_data_i,
    output logic                                          sram_rq_valid_o,
    output logic                                          sram_rq_wr_o,
    output logic [$clog2(numRows)-1:0]                    sram_addr_o,
    output logic [numCols-1:0]                            sram_wr_data_o,
    input  logic                                          sram_rq_ready_i,
    output logic                                          mac_en_o,
    output logic [numRows*xBits-1:0]                      x_data_o,
    input  logic [numCols*numAdcBits-1:0]                 adc_out_i,
    output logic                                          res_valid_o,
    input  logic                                          res_ready_i,
    output logic [numCols*accBits(numAdcBits, xBits)-1:0] res_data_o,
    output logic                                          busy_o,
    output logic                                          done_o
);

    localparam int AW = $clog2(numRows);
    localparam int ACC = accBits(numAdcBits, xBits);
    localparam logic [AW-1:0] LAST_ROW = AW'(numRows - 1);
    localparam logic [15:0] LAST_SETTLE = 16'(settleCycles - 1);

    qracc_seq_state_t r_state, w_next;
    logic r_rq_valid;
    logic [AW-1:0] r_row;
    logic [numCols-1:0] r_wr_data;
    logic [15:0] r_cnt, r_vec, r_nv;
    logic [7:0] r_bit, r_nbm1, w_nb;
    logic [numRows*xBits-1:0] r_x;
    logic w_rq_done, w_x_hs;

    assign w_nb = n_input_bits_i < 8'd2 ? 8'd2 : n_input_bits_i > 8'(xBits) ? 8'(xBits) : n_input_bits_i;
    assign w_rq_done = r_rq_valid && sram_rq_ready_i;
    assign w_x_hs = x_ready_o && x_valid_i;

    assign w_ready_o = r_state == LOAD_W && !r_rq_valid;
    assign x_ready_o = r_state == LOAD_X;
    assign sram_rq_valid_o = r_rq_valid;
    assign sram_rq_wr_o = r_rq_valid;
    assign sram_addr_o = r_row;
    assign sram_wr_data_o = r_wr_data;
    assign mac_en_o = r_state inside {SETTLE, LOAD_X, MAC, WAIT_RES};
    assign x_data_o = r_x;
    assign res_valid_o = r_state == WAIT_RES;
    assign busy_o = r_state != IDLE;
    assign done_o = r_state == DONE;

    always_ff @(posedge clk) r_state <= nrst ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = start_i ? (cfg_skip_w_i ? SETTLE : LOAD_W) : IDLE;
            LOAD_W:   w_next = w_rq_done && r_row == LAST_ROW ? SETTLE : LOAD_W;
            SETTLE:   w_next = r_cnt != LAST_SETTLE ? SETTLE : r_nv == 16'd0 ? DONE : LOAD_X;
            LOAD_X:   w_next = x_valid_i ? MAC : LOAD_X;
`ifdef QRACC_BITSERIAL_ACC_EN
            MAC:      w_next = r_bit + 8'd1 == r_nbm1 ? WAIT_RES : MAC;
`else
            MAC:      w_next = WAIT_RES;
`endif
            WAIT_RES: w_next = !res_ready_i ? WAIT_RES : r_bit != r_nbm1 ? MAC : r_vec != r_nv ? LOAD_X : DONE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_rq_valid <= 1'b0;
            r_row      <= '0;
            r_wr_data  <= '0;
            r_cnt      <= '0;
            r_vec      <= '0;
            r_nv       <= '0;
            r_bit      <= '0;
            r_nbm1     <= '0;
            r_x        <= '0;
        end else begin
            if (r_state == IDLE && start_i) begin
                r_nv   <= n_vectors_i;
                r_nbm1 <= w_nb - 8'd1;
                r_row  <= '0;
                r_cnt  <= '0;
                r_vec  <= '0;
            end
            if (w_ready_o && w_valid_i) begin
                r_rq_valid <= 1'b1;
                r_wr_data  <= w_data_i;
            end
            if (w_rq_done) begin
                r_rq_valid <= 1'b0;
                r_row      <= r_row == LAST_ROW ? '0 : r_row + 1'b1;
            end
            if (r_state == SETTLE) r_cnt <= r_cnt == LAST_SETTLE ? '0 : r_cnt + 16'd1;
            if (w_x_hs) begin
                r_x   <= x_data_i;
                r_vec <= r_vec + 16'd1;
                r_bit <= '0;
            end
            if (r_state == MAC) r_bit <= r_bit + 8'd1;
        end
    end

`ifdef QRACC_BITSERIAL_ACC_EN
    qracc_bs_accum #(
        .numCols(numCols), .numAdcBits(numAdcBits), .accW(ACC)
    ) u_accum (
        .clk(clk), .nrst(nrst), .clr_i(w_x_hs), .en_i(r_state == MAC), .adc_i(adc_out_i), .acc_o(res_data_o)
    );
`else
    logic [numCols*ACC-1:0] w_sext, r_res;
    for (genvar i = 0; i < numCols; i++) begin : g_ext
        assign w_sext[i*ACC +: ACC] = {{xBits{adc_out_i[i*numAdcBits+numAdcBits-1]}}, adc_out_i[i*numAdcBits +: numAdcBits]};
    end
    // raw per-bit result is captured on the bit-cycle edge and held through WAIT_RES
    always_ff @(posedge clk)
        if (nrst) r_res <= '0;
        else if (r_state == MAC) r_res <= w_sext;
    assign res_data_o = r_res;
`endif

endmodule

// File: tb/tb_qracc_mac_sequencer.sv
// tb_qracc_mac_sequencer: randomized self-checking bench against a result-queue model of the sequencer
module tb_qracc_mac_sequencer;

    localparam int NR = 4, NC = 4, AB = 4, XB = 3, SC = 5, RW = AB + XB, AW = 2, XW = NR * XB;

    logic clk = 1'b0;
    logic nrst, start_i, cfg_skip_w_i, w_valid_i, x_valid_i, sram_rq_ready_i, res_ready_i;
    logic [15:0] n_vectors_i;
    logic [7:0] n_input_bits_i;
    logic [NC-1:0] w_data_i, sram_wr_data_o;
    logic [XW-1:0] x_data_i, x_data_o;
    logic [NC*AB-1:0] adc_out_i;
    logic [NC*RW-1:0] res_data_o;
    logic [AW-1:0] sram_addr_o;
    logic w_ready_o, x_ready_o, sram_rq_valid_o, sram_rq_wr_o, mac_en_o, res_valid_o, busy_o, done_o;
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    qracc_mac_sequencer #(
        .numRows(NR), .numCols(NC), .numAdcBits(AB), .xBits(XB), .settleCycles(SC)
    ) u_dut (
        .clk(clk), .nrst(nrst), .start_i(start_i), .cfg_skip_w_i(cfg_skip_w_i),
        .n_vectors_i(n_vectors_i), .n_input_bits_i(n_input_bits_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
        .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .x_data_i(x_data_i),
        .sram_rq_valid_o(sram_rq_valid_o), .sram_rq_wr_o(sram_rq_wr_o), .sram_addr_o(sram_addr_o),
        .sram_wr_data_o(sram_wr_data_o), .sram_rq_ready_i(sram_rq_ready_i),
        .mac_en_o(mac_en_o), .x_data_o(x_data_o), .adc_out_i(adc_out_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    task automatic run_job(input bit skip, input int nv, input int nib, input int rdly, input int bp,
                           input bit dir, input int abort_vec);
        int nb, bits, w_idx, row_exp, hold, vec_sent, cur_bit, macc, rheld, cyc;
        bit pres, pres_n, x_seen, fin, aborted;
        int accm[NC];
        int av[NC];
        logic [NC-1:0] wrow[NR];
        logic [NC*RW-1:0] exp_q[$];
        logic [NC*RW-1:0] ev, e;
        logic [XW-1:0] cur_x, nxt_x;
        nb = nib < 2 ? 2 : (nib > XB ? XB : nib);
        bits = nb - 1;
        for (int i = 0; i < NR; i++) wrow[i] = dir ? NC'(i + 1) : NC'($urandom);
        w_idx = 0; row_exp = 0; hold = 0; vec_sent = 0; cur_bit = 0; macc = 0; rheld = 0; cyc = 0;
        pres = 0; x_seen = 0; fin = 0; aborted = 0;
        cur_x = '0;
        nxt_x = XW'($urandom);
        for (int l = 0; l < NC; l++) accm[l] = 0;
        @(negedge clk);
        start_i = 1; cfg_skip_w_i = skip; n_vectors_i = 16'(nv); n_input_bits_i = 8'(nib);
        @(negedge clk);
        while (!fin && cyc < 3000) begin
            cyc++;
            start_i = 0;
            sram_rq_ready_i = 0;
            if (sram_rq_valid_o) begin
                hold++;
                n_checks++;
                if (skip || row_exp >= NR || sram_rq_wr_o !== 1'b1 || sram_addr_o !== AW'(row_exp) ||
                    sram_wr_data_o !== wrow[row_exp % NR]) begin
                    n_fail++;
                    $display("FAIL sram_rq got wr=%b addr=%0d data=%h, expected wr=1 addr=%0d data=%h (skip=%0d)",
                             sram_rq_wr_o, sram_addr_o, sram_wr_data_o, row_exp, wrow[row_exp % NR], skip);
                end
                if (hold == rdly + 1) begin
                    sram_rq_ready_i = 1;
                    hold = 0;
                    row_exp++;
                end
            end else if (hold > 0) begin
                n_checks++; n_fail++;
                $display("FAIL sram_rq_hold request dropped after %0d cycles, expected %0d", hold, rdly + 1);
                hold = 0;
            end
            w_valid_i = !skip && w_idx < NR;
            w_data_i = wrow[w_idx % NR];
            if (w_valid_i && w_ready_o) w_idx++;
            pres_n = 0;
            if (pres) begin
                for (int l = 0; l < NC; l++) begin
                    av[l] = dir ? (cur_bit == 0 ? 3 : -2) : int'($urandom_range(0, 15)) - 8;
                    adc_out_i[l*AB +: AB] = AB'(av[l]);
                    accm[l] = accm[l] * 2 + av[l];
                    ev[l*RW +: RW] = RW'(av[l]);
                end
                cur_bit++;
`ifdef QRACC_BITSERIAL_ACC_EN
                if (cur_bit < bits) pres_n = 1;
                else begin
                    for (int l = 0; l < NC; l++) ev[l*RW +: RW] = RW'(accm[l]);
                    exp_q.push_back(ev);
                end
`else
                exp_q.push_back(ev);
`endif
            end
            if (abort_vec != 0 && vec_sent == abort_vec && pres) begin
                nrst = 1;
                fin = 1;
                aborted = 1;
            end
            x_valid_i = vec_sent < nv;
            x_data_i = nxt_x;
            if (x_ready_o && !x_seen) begin
                x_seen = 1;
                n_checks++;
                if (macc != SC) begin
                    n_fail++;
                    $display("FAIL settle_len mac_en high %0d cycles before LOAD_X, expected %0d", macc, SC);
                end
            end
            if (x_ready_o && x_valid_i) begin
                cur_x = nxt_x;
                nxt_x = XW'($urandom);
                vec_sent++;
                cur_bit = 0;
                for (int l = 0; l < NC; l++) accm[l] = 0;
                pres_n = 1;
            end
            if (!x_seen && mac_en_o) macc++;
            res_ready_i = 0;
            if (res_valid_o) begin
                e = exp_q.size() != 0 ? exp_q[0] : 'x;
                n_checks++;
                if (exp_q.size() == 0 || res_data_o !== e || x_data_o !== cur_x) begin
                    n_fail++;
                    $display("FAIL result got data=%h x=%h, expected data=%h x=%h (pending=%0d)",
                             res_data_o, x_data_o, e, cur_x, exp_q.size());
                end
                rheld++;
                if (rheld > bp) begin
                    res_ready_i = 1;
                    rheld = 0;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    if (cur_bit < bits) pres_n = 1;
                end
            end
            if (done_o && !aborted) begin
                n_checks++;
                if (exp_q.size() != 0 || vec_sent != nv || row_exp != (skip ? 0 : NR) || mac_en_o !== 1'b0 ||
                    busy_o !== 1'b1 || (nv == 0 && macc != SC)) begin
                    n_fail++;
                    $display("FAIL done_state pending=%0d vecs=%0d/%0d rows=%0d mac_en=%b busy=%b settle=%0d",
                             exp_q.size(), vec_sent, nv, row_exp, mac_en_o, busy_o, macc);
                end
                fin = 1;
            end
            pres = pres_n;
            @(negedge clk);
        end
        w_valid_i = 0; x_valid_i = 0; res_ready_i = 0; sram_rq_ready_i = 0;
        n_checks++;
        if (!fin) begin
            n_fail++;
            $display("FAIL job_timeout no done_o after %0d cycles, expected done", cyc);
            nrst = 1;
            @(negedge clk);
            nrst = 0;
        end else if (aborted) begin
            if ({sram_rq_valid_o, mac_en_o, res_valid_o, w_ready_o, x_ready_o, busy_o, done_o} !== 7'b0 ||
                x_data_o !== '0) begin
                n_fail++;
                $display("FAIL abort_outputs got rq=%b mac=%b res=%b wr=%b xr=%b busy=%b done=%b x=%h, expected all 0",
                         sram_rq_valid_o, mac_en_o, res_valid_o, w_ready_o, x_ready_o, busy_o, done_o, x_data_o);
            end
            nrst = 0;
        end else if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done got busy=%b done=%b, expected 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_reset();
        nrst = 1; start_i = 0; cfg_skip_w_i = 0; n_vectors_i = '0; n_input_bits_i = '0;
        w_valid_i = 0; w_data_i = '0; x_valid_i = 0; x_data_i = '0; sram_rq_ready_i = 0;
        adc_out_i = '0; res_ready_i = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sram_rq_valid_o, sram_rq_wr_o, mac_en_o, res_valid_o, w_ready_o, x_ready_o, busy_o, done_o} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b, expected 00000000",
                     {sram_rq_valid_o, sram_rq_wr_o, mac_en_o, res_valid_o, w_ready_o, x_ready_o, busy_o, done_o});
        end
        n_checks++;
        if (x_data_o !== '0 || sram_addr_o !== '0 || res_data_o !== '0) begin
            n_fail++;
            $display("FAIL reset_data got x=%h addr=%0d res=%h, expected 0 0 0", x_data_o, sram_addr_o, res_data_o);
        end
        nrst = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_start got busy=%b, expected 0", busy_o);
        end
    endtask

    task automatic test_weight_load();
        run_job(0, 1, 3, 2, 0, 1, 0);
    endtask

    task automatic test_skip();
        run_job(1, 0, 2, 0, 0, 0, 0);
    endtask

    task automatic test_directed();
        run_job(1, 1, 3, 0, 4, 1, 0);
    endtask

    task automatic test_clamp();
        run_job(1, 2, 0, 0, 0, 0, 0);
        run_job(1, 2, 9, 0, 1, 0, 0);
        run_job(1, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_job();
        run_job(1, 3, 3, 0, 0, 0, 2);
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (sram_rq_valid_o !== 1'b0 || res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL post_abort got rq=%b res=%b busy=%b, expected 0 0 0", sram_rq_valid_o, res_valid_o, busy_o);
            end
        end
        run_job(0, 3, 3, 1, 1, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 8; j++)
            run_job(1'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0, 0);
    endtask

    initial begin
        test_reset();
        test_weight_load();
        test_skip();
        test_directed();
        test_clamp();
        test_reset_mid_job();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qracc_mac_sequencer.md
QRACC_MAC_SEQUENCER -- requirements
Module: qracc_mac_sequencer

Interface
REQ-001 SHALL have parameter numRows, default 128, SRAM rows and MAC input lanes.
REQ-002 SHALL have parameter numCols, default 32, SRAM columns and ADC channels.
REQ-003 SHALL have parameter numAdcBits, default 4, ADC code width (signed).
REQ-004 SHALL have parameter xBits, default 2, maximum input width (two's complement).
REQ-005 SHALL have parameter settleCycles, default 5, mac_en warm-up cycles before the first vector.
REQ-006 SHALL have ports: clk in 1 clock; nrst in 1 reset; one clock; reset is synchronous and active-high.
REQ-007 SHALL have ports: start_i in 1 begin job; cfg_skip_w_i in 1 bypass weight load; n_vectors_i in 16 vectors per job; n_input_bits_i in 8 active input width.
REQ-008 SHALL have ports: w_valid_i in 1, w_ready_o out 1, w_data_i in numCols; weight-row stream.
REQ-009 SHALL have ports: x_valid_i in 1, x_ready_o out 1, x_data_i in numRows*xBits; input-vector stream.
REQ-010 SHALL have ports: sram_rq_valid_o out 1, sram_rq_wr_o out 1, sram_addr_o out clog2(numRows), sram_wr_data_o out numCols, sram_rq_ready_i in 1; wrapper SRAM request port.
REQ-011 SHALL have ports: mac_en_o out 1, x_data_o out numRows*xBits, adc_out_i in numCols*numAdcBits; wrapper MAC port.
REQ-012 SHALL have ports: res_valid_o out 1, res_ready_i in 1, res_data_o out numCols*accBits; busy_o out 1; done_o out 1.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD_W, SETTLE, LOAD_X, MAC, WAIT_RES, DONE.
REQ-014 IDLE: start_i=1 -> LOAD_W, or SETTLE if cfg_skip_w_i=1; job config is latched on that edge; start_i is ignored outside IDLE.
REQ-015 LOAD_W: w_ready_o=1 only when no SRAM request is pending; an accepted row drives sram_rq_valid_o=1, sram_rq_wr_o=1, and sram_addr_o equal to a row counter starting at 0.
REQ-016 The request SHALL be held stable until sram_rq_ready_i=1; the counter then increments; completion of row numRows-1 -> SETTLE, counter wraps to 0.
REQ-017 SETTLE: mac_en_o=1 for exactly settleCycles cycles -> LOAD_X, or DONE if the latched n_vectors=0.
REQ-018 LOAD_X: x_ready_o=1; a handshake registers x_data_i into x_data_o -> MAC; mac_en_o stays 1 from SETTLE until DONE.
REQ-019 MAC: runs nb-1 bit cycles, where nb = latched n_input_bits clamped to [2, xBits]; adc_out_i is sampled on each bit-cycle edge.
REQ-020 WAIT_RES: res_valid_o=1 holding res_data_o until res_ready_i=1; x_data_o is held meanwhile.
REQ-021 After a result is accepted: more bits remain -> MAC; vector count < n_vectors -> LOAD_X; otherwise -> DONE.
REQ-022 DONE: done_o=1 for one cycle, mac_en_o=0 -> IDLE; busy_o=1 in every state except IDLE.
REQ-023 Each ADC lane SHALL be sign-extended to accBits = numAdcBits+xBits; lanes stay independent with no cross-lane carry.

Reset
REQ-024 nrst=1 at a clock edge -> IDLE, all counters 0, x_data_o=0, and every output 0 (sram_rq_valid_o, mac_en_o, res_valid_o, w_ready_o, x_ready_o, busy_o, done_o).
REQ-025 Reset mid-job SHALL abandon the job with no further SRAM request or result; sram_rq_valid_o drops on that edge.

Configuration
REQ-026 Feature macro QRACC_BITSERIAL_ACC_EN SHALL control result accumulation.
REQ-027 With the macro defined: per lane acc <= (acc<<1) + adc on each bit cycle, acc cleared per vector; one result per vector after bit nb-2, and MAC does not pause between bit cycles.
REQ-028 With the macro not defined: one result per bit cycle (the sign-extended raw adc), passing through WAIT_RES after every bit cycle.

Structure
REQ-029 The state enum (qracc_seq_state_t) and the accBits function SHALL be added to qracc_pkg.
REQ-030 A single sub-module qracc_bs_accum SHALL hold per-lane sign extension and shift-add; it is instantiated only under the macro.

Verification
REQ-031 Weight load: numRows=4, rows 1,2,3,4, sram_rq_ready_i delayed 2 cycles each -> addresses 0..3 with matching data, each request held 3 cycles, then SETTLE.
REQ-032 Skip path: cfg_skip_w_i=1, n_vectors=0 -> no SRAM request, mac_en_o high exactly 5 cycles, done_o pulse, back to IDLE.
REQ-033 Non-accumulating build: xBits=3, nb=3, adc per lane 3 then -2 -> results 3 and -2 in order, backpressure of 4 cycles holds data stable.
REQ-034 Accumulating build: same stimulus -> single result 3*2+(-2)=4 per lane.
REQ-035 Clamping: n_input_bits_i=0 and =9 with xBits=2 -> exactly 1 bit cycle per vector.
REQ-036 Reset in MAC of vector 2 of 3 -> all outputs 0 next cycle; a new start_i runs a full job correctly.
